iter_divider: RTL

//  Parametrised multi-cycle radix-2 restoring divider. Replaces the vendor signed/unsigned divider
//  IP pair in the EX-stage ALU with one shared unit. Handles signed and unsigned operands, divide-by-zero
//  and cancellation. Handshakes valid/ready on both sides; the ALU stalls on !out_valid.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/iter_divider.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : divider FSM state encoding (2-bit)
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   i_rem      : partial remainder, WIDTH+1 bits
//   i_a_bit    : next dividend bit, MSB first
//   i_divisor  : divisor magnitude
//   o_rem_next : partial remainder after trial subtract / restore
//   o_q_bit    : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_a_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem_next,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    w_shift    = {i_rem, i_a_bit};
    w_diff     = w_shift - {2'b00, i_divisor};
    // No borrow out of the top bit means the trial subtraction succeeded.
    o_q_bit    = ~w_diff[WIDTH+1];
    o_rem_next = o_q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, signed and unsigned, with
// divide-by-zero reporting and flush/cancel.
// Ports:
//   clk, reset (sync, active-high), flush (cancel in-flight op)
//   in_valid/in_ready, in_signed, in_dividend, in_divisor : operand handshake
//   out_valid/out_ready, out_quotient, out_remainder,
//   out_div_zero : result handshake, held until out_ready
//   busy : FSM not idle
// Build option: define ITER_DIV_EARLY_OUT_EN to skip the iteration when the
// divisor is zero or |dividend| < |divisor|.
module iter_divider
  import div_pkg::*;
#(
  parameter  int unsigned WIDTH = DIV_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             busy
);

  div_state_e       r_state;
  logic             r_live;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div_zero;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_lo;
  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic             w_accept;
  logic             w_last;
  logic             w_b_zero;

  always_comb begin
    w_abs_a  = (in_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
    w_abs_b  = (in_signed && in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;
    w_b_zero = (in_divisor == '0);
    w_rem_lo = r_rem[WIDTH-1:0];
    w_accept = in_valid && in_ready && !flush;
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem      (r_rem),
    .i_a_bit    (r_quo[WIDTH-1]),
    .i_divisor  (r_divisor),
    .o_rem_next (w_rem_next),
    .o_q_bit    (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_live      <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
        r_div_zero  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_cnt      <= '0;
              r_rem      <= '0;
              r_divisor  <= w_abs_b;
              r_div_zero <= w_b_zero;
              r_state    <= CALC;
              // A zero divisor iterates on the raw dividend with signs cleared:
              // every step then succeeds, leaving quotient all-ones and the
              // remainder equal to the unmodified dividend.
              if (w_b_zero) begin
                r_quo    <= in_dividend;
                r_sign_q <= 1'b0;
                r_sign_r <= 1'b0;
              end else begin
                r_quo    <= w_abs_a;
                r_sign_q <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                r_sign_r <= in_signed & in_dividend[WIDTH-1];
              end
`ifdef ITER_DIV_EARLY_OUT_EN
              if (w_b_zero) begin
                r_quo   <= '1;
                r_rem   <= {1'b0, in_dividend};
                r_state <= FIX;
              end else if (w_abs_a < w_abs_b) begin
                r_quo   <= '0;
                r_rem   <= {1'b0, w_abs_a};
                r_state <= FIX;
              end
`endif
            end
          end
          CALC: begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= FIX;
          end
          FIX: begin
            r_quotient  <= r_sign_q ? -r_quo    : r_quo;
            r_remainder <= r_sign_r ? -w_rem_lo : w_rem_lo;
            r_state     <= DONE;
          end
          DONE: begin
            // out_valid is registered, rising one cycle after entering DONE.
            if (!r_out_valid) begin
              r_out_valid <= 1'b1;
            end else if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign in_ready      = (r_state == IDLE) && r_live;
  assign busy          = (r_state != IDLE);
  assign out_valid     = r_out_valid;
  assign out_quotient  = r_quotient;
  assign out_remainder = r_remainder;
  assign out_div_zero  = r_div_zero;

endmodule
